embnew16k_pio_seq: RTL
======================

EMBNEW16K_PIO_SEQ -- requirements
Module: embnew16k_pio_seq

Interface
REQ-001 DEPTH, 8, number of pattern-table entries; the pattern-table index is 3 bits.
REQ-002 DWELL_RST, 16'd0, reset value of the DWELL register.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  3  config slave word address.
REQ-006 chipselect  in  1  config slave select.
REQ-007 write_n  in  1  config slave write strobe, active-low; a write occurs when chipselect && !write_n.
REQ-008 writedata  in  32  config slave write data.
REQ-009 readdata  out  32  config slave read data; combinational from address, zero-extended.
REQ-010 m_address  out  3  PIO master word address (0=write, 4=set bits, 5=clear bits).
REQ-011 m_chipselect  out  1  PIO master select.
REQ-012 m_write_n  out  1  PIO master write strobe, active-low.
REQ-013 m_writedata  out  32  PIO master data; bits [31:8] are always 0.
REQ-014 m_waitrequest  in  1  PIO stall; the master holds all outputs while it is high.
REQ-015 irq  out  1  sticky sequence-done flag.

Function
REQ-016 Register map (address: access, fields):
- 0 CTRL (write-only, reads 0): bit0 start pulse; bit1 loop; bit2 stop pulse. Loop is stored and reads back at STATUS bit2.
- 1 STATUS: bit0 busy (RO); bit1 irq (write 1 to clear); bit2 loop; bits[6:4] current index.
- 2 DWELL (RW): bits[15:0].
- 3 LAST (RW): bits[2:0], index of the final entry.
- 4 PIDX (RW): bits[2:0], table write pointer.
- 5 PDATA (WO): writes the entry at PIDX, then PIDX increments modulo DEPTH; [7:0] value, [9:8] op.
- 6, 7: reads 0, writes ignored.
REQ-017 Op codes: 00 drives m_address=0; 01 drives m_address=4; 10 drives m_address=5; 11 is skip (no bus transaction; dwell only).
REQ-018 FSM states are IDLE, ISSUE, DWELL and NEXT; busy=1 in every state except IDLE.
REQ-019 IDLE -> ISSUE (or DWELL for a skip op) on a start write; the index resets to 0; m_chipselect rises the cycle after the write.
REQ-020 In ISSUE, the block drives m_chipselect=1, m_write_n=0, and the address/data of the current entry.
REQ-021 The ISSUE transaction completes on the first edge with m_waitrequest=0; ISSUE then -> DWELL, and m_chipselect=0 the following cycle.
REQ-022 DWELL waits exactly DWELL cycles, then goes to NEXT; DWELL=0 spends one cycle in DWELL.
REQ-023 NEXT behaviour:
- index != LAST: index+1, then ISSUE or DWELL per op.
- index == LAST with loop=1: index wraps to 0 and continues.
- index == LAST with loop=0: sets irq and goes to IDLE.
REQ-024 A stop write while in ISSUE lets the pending transaction complete, then goes to IDLE. In DWELL or NEXT it goes to IDLE the next cycle. A stopped sequence does not set irq.
REQ-025 A start write while busy is ignored. A simultaneous start+stop write while in IDLE is ignored.
REQ-026 PIDX, PDATA and LAST writes while busy are ignored; DWELL and loop writes take effect at the next dwell start and the next NEXT evaluation respectively.
REQ-027 If irq-set and an irq-clear write fall in the same cycle, set wins.
REQ-028 The master never issues back-to-back transactions; there is at least 1 idle cycle between them.

Reset
REQ-029 Reset state:
- FSM=IDLE; index=0, PIDX=0, LAST=0, loop=0, irq=0, DWELL=DWELL_RST.
- m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- Table contents are undefined.
REQ-030 A reset asserted during ISSUE drops m_chipselect on the next edge, regardless of m_waitrequest.

Verification
REQ-031 Set PIDX=0; PDATA=0x0A5,0x10F,0x201; LAST=2; DWELL=3; start. Expect writes in order: addr0 0xA5, addr4 0x0F, addr5 0x01; 5 cycles between chipselect rises; irq=1; busy=0.
REQ-032 Same as REQ-031 with m_waitrequest held high 4 cycles on the second write. Expect address/data stable throughout the stall and the sequence completes correctly.
REQ-033 Loop=1, LAST=1, DWELL=0. Expect the write pattern repeats with index wrapping 1->0; stop in DWELL gives busy=0 next cycle and irq stays 0.
REQ-034 Entry op=11 between two writes. Expect no bus transaction for that entry and a gap equal to the dwell.
REQ-035 Start while busy, PDATA write while busy, irq set coincident with clear. Expect all ignored / set wins; the table is unchanged.
REQ-036 Reset pulsed mid-ISSUE with m_waitrequest=1. Expect m_chipselect=0, busy=0, irq=0 on the next edge.

Source files
------------

// File: rtl/embnew16k_pio_seq.sv
// embnew16k_pio_seq: pattern-table driven PIO write sequencer with a config slave
module embnew16k_pio_seq #(
  parameter int DEPTH = 8,
  parameter logic [15:0] DWELL_RST = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, ISSUE, DWELL, NEXT} state_t;
  state_t state, state_nx;
  logic [7:0] tbl_val [DEPTH];
  logic [1:0] tbl_op [DEPTH];
  logic [2:0] idx, idx_nx, pidx, last;
  logic [15:0] dwell, cnt;
  logic [1:0] cur_op;
  logic loop, busy, wr, start, stop, stop_pend, last_hit, irq_set, irq_clr;
  logic unused_wdata;

  assign wr = chipselect && !write_n;
  assign busy = state != IDLE;
  assign start = wr && address == 3'd0 && writedata[0] && !writedata[2] && !busy;
  assign stop = wr && address == 3'd0 && writedata[2];
  assign last_hit = idx == last;
  assign idx_nx = last_hit ? 3'd0 : idx + 3'd1;
  assign irq_set = state == NEXT && last_hit && !loop && !stop;
  assign irq_clr = wr && address == 3'd1 && writedata[1];
  assign cur_op = tbl_op[idx];
  assign unused_wdata = ^writedata[31:16];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = tbl_op[0] == 2'b11 ? DWELL : ISSUE;
      ISSUE: if (!m_waitrequest) state_nx = (stop || stop_pend) ? IDLE : DWELL;
      DWELL: state_nx = stop ? IDLE : (cnt <= 16'd1 ? NEXT : DWELL);
      NEXT:  state_nx = (stop || (last_hit && !loop)) ? IDLE : (tbl_op[idx_nx] == 2'b11 ? DWELL : ISSUE);
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= 3'd0;
      pidx <= 3'd0;
      last <= 3'd0;
      loop <= 1'b0;
      irq <= 1'b0;
      dwell <= DWELL_RST;
      cnt <= 16'd0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nx;
      // a stop seen mid-stall is remembered until the pending write completes
      stop_pend <= state == ISSUE && state_nx == ISSUE && (stop || stop_pend);
      if (state_nx == DWELL && state != DWELL) cnt <= dwell;
      else if (state == DWELL) cnt <= cnt - 16'd1;
      if (start) idx <= 3'd0;
      else if (state == NEXT && state_nx != IDLE) idx <= idx_nx;
      if (wr && address == 3'd0) loop <= writedata[1];
      if (wr && address == 3'd2) dwell <= writedata[15:0];
      if (wr && !busy && address == 3'd3) last <= writedata[2:0];
      if (wr && !busy && address == 3'd4) pidx <= writedata[2:0];
      else if (wr && !busy && address == 3'd5) pidx <= pidx + 3'd1;
      irq <= irq_set || (irq && !irq_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !busy && address == 3'd5) begin
      tbl_val[pidx] <= writedata[7:0];
      tbl_op[pidx] <= writedata[9:8];
    end
  end

  assign m_chipselect = state == ISSUE;
  assign m_write_n = !m_chipselect;
  assign m_address = !m_chipselect ? 3'd0 : cur_op == 2'b01 ? 3'd4 : cur_op == 2'b10 ? 3'd5 : 3'd0;
  assign m_writedata = m_chipselect ? {24'd0, tbl_val[idx]} : 32'd0;
  assign readdata = address == 3'd1 ? {25'd0, idx, 1'b0, loop, irq, busy} :
                    address == 3'd2 ? {16'd0, dwell} :
                    address == 3'd3 ? {29'd0, last} :
                    address == 3'd4 ? {29'd0, pidx} : 32'd0;
endmodule
